uart_wb_bridge: RTL and testbench
=================================

Name: uart_wb_bridge

Overview:
- Byte-stream command bridge between a UART receive/transmit byte interface and the SoC Wishbone bus.
- Sits downstream of the SoC UART receiver. It parses framed read/write commands from the host cable and issues single 32-bit Wishbone master cycles.
- It returns response bytes to the UART transmitter.
- It gives the host and the bench a firmware-independent debug path into the SoC address map.

Parameters:
- TIMEOUT_CYCLES, 255: Wishbone cycles to wait for ack/err before aborting. Used only with the optional feature.
- WB_SEL, 4'hF: byte-select driven on every cycle.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous reset, active-high
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  bridge accepts a byte
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  transmitter accepts a byte
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_sel_o  out  4  byte select
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high.
- Reset values: all outputs 0 except rx_ready_o=1; state=IDLE.
- Byte transfers:
  - A byte is accepted on an edge where rx_valid_i & rx_ready_o.
  - A byte is sent on an edge where tx_valid_o & tx_ready_i.
- Frame format:
  - Command byte: 8'h57 'W' or 8'h52 'R'.
  - 4 address bytes, MSB first.
  - 'W' only: 4 data bytes, MSB first.
- States:
  - IDLE: rx_ready_o=1. 'W' or 'R' latches we_r and goes to ADDR. Any other byte is consumed and dropped; state stays IDLE.
  - ADDR: rx_ready_o=1. Shifts the address left 8 bits per byte, with a 2-bit byte counter. After the 4th byte: 'W' goes to DATA, 'R' goes to BUS.
  - DATA: rx_ready_o=1. Shifts write data the same way. After the 4th byte, goes to BUS.
  - BUS: rx_ready_o=0.
    - wbm_cyc_o, wbm_stb_o and wbm_we_o=we_r are asserted starting the cycle after the last frame byte is accepted.
    - wbm_adr_o, wbm_dat_o and wbm_sel_o=WB_SEL are held stable while cyc is high.
    - On an edge with ack: read data is latched, cyc/stb drop, next state is RESP.
    - On an edge with err, or with ack and err together: err wins, and the error flag is set.
  - RESP: rx_ready_o=0. tx_valid_o=1, and tx_data_o is held until accepted.
    - Success, read: 4 data bytes, MSB first.
    - Success, write: one byte 8'h4B 'K'.
    - Error: one byte 8'h45 'E'.
    - After the last byte is accepted, return to IDLE.
- Boundaries:
  - Bytes arriving while in BUS/RESP are back-pressured, not dropped.
  - A gap of any length between frame bytes is allowed.
  - Reset mid-frame or mid-bus-cycle: cyc/stb/tx_valid are 0 and state is IDLE on the edge reset is sampled. A partial frame is discarded.
  - The byte counter wraps 3->0 only at a state change.
- Minimum latency: a write with ack in the first bus cycle gives 'K' on tx_valid_o 2 cycles after the last data byte is accepted.

Optional Feature:
- Macro: UART_WB_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches TIMEOUT_CYCLES without ack/err, cyc/stb drop, the error flag is set, and the bridge responds 'E'.
- Undefined: no counter, and BUS waits indefinitely.

Decomposition:
- Shared header uart_wb_bridge_defines.vh (package role) holds:
  - Command codes CMD_WR=8'h57, CMD_RD=8'h52.
  - Response codes RSP_OK=8'h4B, RSP_ERR=8'h45.
  - State encodings IDLE/ADDR/DATA/BUS/RESP.
- One sub-module is natural: uart_wb_bridge_timeout, the optional watchdog counter with start/clear/expire ports. It is instantiated only under the macro.
- Frame shifting and the FSM stay in the top module.

Test Plan:
- Write: bytes 57 00 00 10 04 DE AD BE EF -> one cycle with wbm_we_o=1, adr=32'h0000_1004, dat_o=32'hDEAD_BEEF, sel=4'hF; then tx 8'h4B.
- Read: 52 00 00 10 04, slave acks with 32'h1234_5678 after 3 wait states -> tx 12 34 56 78 in order, then busy_o=0.
- Junk filter: 00 FF 52 00 00 00 00 -> junk bytes consumed without effect; one read cycle at adr 0.
- Bus error: write frame, slave asserts wbm_err_i -> cyc drops the next edge; tx 8'h45 only.
- Backpressure and reset:
  - tx_ready_i held low 10 cycles during RESP -> tx_data_o stable, rx_ready_o=0.
  - Assert wb_rst_i while wbm_cyc_o=1 -> cyc=0 and rx_ready_o=1 after that edge; the next full frame works.
- Timeout (macro defined, TIMEOUT_CYCLES=16): slave never acks -> cyc drops after 16 BUS cycles; tx 8'h45.

Source files
------------

// File: rtl/uart_wb_bridge_pkg.sv
// Shared command/response codes, FSM state encoding and widths for uart_wb_bridge.
// The watchdog counter width applies only when UART_WB_BRIDGE_TIMEOUT_EN is defined.
package uart_wb_bridge_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ADR_W    = 32;
  localparam int unsigned DAT_W    = 32;
  localparam int unsigned TO_CNT_W = 16;

  localparam logic [BYTE_W-1:0] CMD_WR  = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_RD  = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_OK  = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/uart_wb_bridge_timeout.sv
// Watchdog for the bridge's Wishbone cycle: clears while idle, counts bus cycles,
// flags expiry on the LIMIT-th counted cycle. Instantiated only under UART_WB_BRIDGE_TIMEOUT_EN.
module uart_wb_bridge_timeout
  import uart_wb_bridge_pkg::*;
#(
  parameter int unsigned CNT_W = TO_CNT_W,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic start_i,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = start_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/uart_wb_bridge.sv
// UART byte-stream to Wishbone single-cycle master: parses 'W'/'R' frames, answers K/E/read data.
// Optional bus watchdog enabled by defining UART_WB_BRIDGE_TIMEOUT_EN.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter logic [3:0] WB_SEL = 4'hF
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  output logic [3:0]        wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              busy_o
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADR_W-1:0]    adr_q, adr_d;
  logic [DAT_W-1:0]    dat_q, dat_d;
  logic [DAT_W-1:0]    rdat_q, rdat_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                rx_ready_q, rx_ready_d;
  logic                tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                cyc_q, cyc_d;
  logic                we_out_q, we_out_d;
  logic [3:0]          sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                rx_fire_c;
  logic                tx_fire_c;
  logic                timeout_c;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  uart_wb_bridge_timeout #(
    .CNT_W (TO_CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clear_i  (state_q != ST_BUS),
    .start_i  (state_q == ST_BUS),
    .expire_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  assign rx_fire_c = rx_valid_i & rx_ready_q;
  assign tx_fire_c = tx_valid_q & tx_ready_i;

  // Frame parser, bus handshake and response sequencing
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rdat_d    = rdat_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire_c && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) begin
          we_d    = (rx_data_i == CMD_WR);
          cnt_d   = 2'd0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_fire_c) begin
          adr_d = {adr_q[ADR_W-BYTE_W-1:0], rx_data_i};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = we_q ? ST_DATA : ST_BUS;
            err_d   = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (rx_fire_c) begin
          dat_d = {dat_q[DAT_W-BYTE_W-1:0], rx_data_i};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_BUS;
            err_d   = 1'b0;
          end
        end
      end
      ST_BUS: begin
        // err takes priority over a simultaneous ack
        if (wbm_err_i || timeout_c) begin
          err_d     = 1'b1;
          tx_data_d = RSP_ERR;
          cnt_d     = 2'd0;
          state_d   = ST_RESP;
        end else if (wbm_ack_i) begin
          rdat_d    = wbm_dat_i;
          tx_data_d = we_q ? RSP_OK : wbm_dat_i[DAT_W-1 -: BYTE_W];
          cnt_d     = 2'd0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_fire_c) begin
          if (!we_q && !err_q && cnt_q != 2'd3) begin
            cnt_d     = cnt_q + 2'd1;
            rdat_d    = {rdat_q[DAT_W-BYTE_W-1:0], 8'h00};
            tx_data_d = rdat_q[DAT_W-BYTE_W-1 -: BYTE_W];
          end else begin
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the next state so they are registered and aligned with it
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    cyc_d      = (state_d == ST_BUS);
    we_out_d   = cyc_d & we_d;
    sel_d      = cyc_d ? WB_SEL : 4'h0;
    tx_valid_d = (state_d == ST_RESP);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rdat_q     <= '0;
      cnt_q      <= 2'd0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cyc_q      <= 1'b0;
      we_out_q   <= 1'b0;
      sel_q      <= 4'h0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rdat_q     <= rdat_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cyc_q      <= cyc_d;
      we_out_q   <= we_out_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_we_o   = we_out_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: write, read, junk, bus error, backpressure, reset,
// and the watchdog case when UART_WB_BRIDGE_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_uart_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  localparam int LIM = 200;

  always #5 clk = ~clk;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  uart_wb_bridge #(.WB_SEL(4'hF), .TIMEOUT_CYCLES(16)) dut (
`else
  uart_wb_bridge #(.WB_SEL(4'hF)) dut (
`endif
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_o),
    .wbm_dat_i  (dat_i),
    .wbm_sel_o  (sel),
    .wbm_we_o   (we),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_ack_i  (ack),
    .wbm_err_i  (err),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("rx_wait_bound", 32'(n), 32'(LIM - 1));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (cmd == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk({tag, "_wait_bound"}, 32'(n), 32'(LIM - 1));
    chk(tag, 32'(tx_data), 32'(exp));
    @(negedge clk);
  endtask

  // Holds for nwait cycles (cyc must stay up), then pulses ack or err for one edge
  task automatic bus_reply(input int nwait, input logic [31:0] rd, input logic e);
    for (int i = 0; i < nwait; i++) begin
      chk("cyc_wait", 32'(cyc), 32'd1);
      @(negedge clk);
    end
    dat_i = rd;
    ack   = ~e;
    err   = e;
    @(negedge clk);
    ack   = 1'b0;
    err   = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Write with immediate ack
    send_frame(8'h57, 32'h0000_1004, 32'hDEAD_BEEF);
    chk("wr_cyc", 32'(cyc), 32'd1);
    chk("wr_stb", 32'(stb), 32'd1);
    chk("wr_we", 32'(we), 32'd1);
    chk("wr_adr", adr, 32'h0000_1004);
    chk("wr_dat", dat_o, 32'hDEAD_BEEF);
    chk("wr_sel", 32'(sel), 32'hF);
    chk("wr_rx_ready", 32'(rx_ready), 32'd0);
    bus_reply(0, 32'h0, 1'b0);
    chk("wr_cyc_drop", 32'(cyc), 32'd0);
    chk("wr_tx_valid", 32'(tx_valid), 32'd1);
    recv_byte("wr_rsp", 8'h4B);
    chk("wr_busy_end", 32'(busy), 32'd0);

    // Read with 3 wait states
    send_frame(8'h52, 32'h0000_1004, 32'h0);
    chk("rd_we", 32'(we), 32'd0);
    chk("rd_adr", adr, 32'h0000_1004);
    bus_reply(3, 32'h1234_5678, 1'b0);
    recv_byte("rd_b0", 8'h12);
    recv_byte("rd_b1", 8'h34);
    recv_byte("rd_b2", 8'h56);
    recv_byte("rd_b3", 8'h78);
    chk("rd_busy_end", 32'(busy), 32'd0);
    chk("rd_tx_valid_end", 32'(tx_valid), 32'd0);

    // Junk bytes dropped in IDLE, then read at address 0
    send_byte(8'h00);
    chk("junk0_busy", 32'(busy), 32'd0);
    send_byte(8'hFF);
    chk("junk1_busy", 32'(busy), 32'd0);
    send_frame(8'h52, 32'h0, 32'h0);
    chk("junk_rd_cyc", 32'(cyc), 32'd1);
    chk("junk_rd_adr", adr, 32'h0);
    bus_reply(0, 32'hA5C3_0F96, 1'b0);
    recv_byte("junk_b0", 8'hA5);
    recv_byte("junk_b1", 8'hC3);
    recv_byte("junk_b2", 8'h0F);
    recv_byte("junk_b3", 8'h96);

    // Bus error on a write
    send_frame(8'h57, 32'h0000_2000, 32'h1122_3344);
    bus_reply(1, 32'h0, 1'b1);
    chk("err_cyc_drop", 32'(cyc), 32'd0);
    recv_byte("err_rsp", 8'h45);
    chk("err_single_byte", 32'(tx_valid), 32'd0);
    chk("err_busy_end", 32'(busy), 32'd0);

    // Transmit backpressure with a pending rx byte
    tx_ready = 1'b0;
    send_frame(8'h52, 32'h0000_0040, 32'h0);
    bus_reply(0, 32'hCAFE_F00D, 1'b0);
    rx_data  = 8'h57;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_data", 32'(tx_data), 32'hCA);
      chk("bp_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    recv_byte("bp_b0", 8'hCA);
    recv_byte("bp_b1", 8'hFE);
    recv_byte("bp_b2", 8'hF0);
    recv_byte("bp_b3", 8'h0D);
    chk("bp_busy_end", 32'(busy), 32'd0);

    // Reset during a bus cycle, then a full write
    send_frame(8'h52, 32'h0000_0080, 32'h0);
    chk("rst_mid_cyc_pre", 32'(cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cyc", 32'(cyc), 32'd0);
    chk("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    send_byte(8'h57);
    send_byte(8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h57, 32'h0000_0300, 32'h0BAD_CAFE);
    chk("post_rst_adr", adr, 32'h0000_0300);
    chk("post_rst_dat", dat_o, 32'h0BAD_CAFE);
    bus_reply(0, 32'h0, 1'b0);
    recv_byte("post_rst_rsp", 8'h4B);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    begin
      int up = 0;
      send_frame(8'h52, 32'h0000_0500, 32'h0);
      while (cyc && up < LIM) begin
        @(negedge clk);
        up++;
      end
      chk("to_cyc_cycles", 32'(up), 32'd16);
      recv_byte("to_rsp", 8'h45);
      chk("to_busy_end", 32'(busy), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
